// File: rtl/clken_gen.sv
// Fractional clock-enable generator.
// Each channel runs a phase accumulator. Every carry out of the accumulator
// produces a one-cycle ce pulse and toggles that channel's outclk square
// wave. A small lock FSM reports when every channel has run undisturbed
// (no increment load and no realignment) for LOCK_CYC cycles.
module clken_gen #(
   parameter int NUM_CH   = 3,
   parameter int ACC_W    = 24,
   parameter int LOCK_CYC = 16
) (
   input  logic                    refclk,
   input  logic                    rst,
   input  logic [NUM_CH*ACC_W-1:0] inc,
   input  logic                    inc_wr,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       ce,
   output logic [NUM_CH-1:0]       outclk,
   output logic                    locked
);

   typedef enum logic {
      SETTLE = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

   // Final settle count; once lcnt reaches this value the FSM locks next edge.
   localparam logic [7:0] LOCK_LAST = 8'(LOCK_CYC - 1);

   logic [ACC_W-1:0] inc_r [NUM_CH];
   logic [ACC_W-1:0] acc   [NUM_CH];
   logic [ACC_W-1:0] sum   [NUM_CH];
   logic [NUM_CH-1:0] carry;

   lock_state_t state;
   lock_state_t state_next;
   logic [7:0]  lcnt;
   logic [7:0]  lcnt_next;
   logic        locked_next;

   // Per-channel modular add; the carry out of the top bit marks a ce event.
   always_comb begin
      carry = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         {carry[i], sum[i]} = {1'b0, acc[i]} + {1'b0, inc_r[i]};
      end
   end

   // Shadow increment registers; a new value takes effect on the following add.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            inc_r[i] <= '0;
         end
      end else if (inc_wr) begin
         for (int i = 0; i < NUM_CH; i++) begin
            inc_r[i] <= inc[i*ACC_W +: ACC_W];
         end
      end
   end

   // Accumulators and registered ce/outclk; sync realigns every channel to zero.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
         end
         ce     <= '0;
         outclk <= '0;
      end else if (sync) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
         end
         ce     <= '0;
         outclk <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= sum[i];
         end
         ce     <= carry;
         outclk <= outclk ^ carry;
      end
   end

   // Lock FSM state register, together with the registered locked flag.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         state  <= SETTLE;
         lcnt   <= '0;
         locked <= 1'b0;
      end else begin
         state  <= state_next;
         lcnt   <= lcnt_next;
         locked <= locked_next;
      end
   end

   // Next-state logic: any disturbance restarts the settle count from zero.
   always_comb begin
      state_next = state;
      lcnt_next  = lcnt;
      if (inc_wr || sync) begin
         state_next = SETTLE;
         lcnt_next  = '0;
      end else begin
         case (state)
            SETTLE: begin
               lcnt_next = lcnt + 8'd1;
               if (lcnt == LOCK_LAST) begin
                  state_next = LOCKED;
               end
            end
            LOCKED: begin
               state_next = LOCKED;
            end
            default: begin
               state_next = SETTLE;
               lcnt_next  = '0;
            end
         endcase
      end
   end

   // Output logic: locked is high exactly while the FSM sits in LOCKED.
   always_comb begin
      locked_next = (state_next == LOCKED);
   end

endmodule

// File: tb/tb_clken_gen.sv
// Self-checking bench for clken_gen with a 4-bit accumulator and 3 channels.
// A behavioural model predicts ce/outclk/locked for every edge; predictions
// are queued when stimulus is driven and popped when the DUT output is sampled.
module tb_clken_gen;

   localparam int NCH  = 3;
   localparam int AW   = 4;
   localparam int LCYC = 16;
   localparam int MODV = 1 << AW;

   logic                refclk;
   logic                rst;
   logic [NCH*AW-1:0]   inc;
   logic                inc_wr;
   logic                sync;
   logic [NCH-1:0]      ce;
   logic [NCH-1:0]      outclk;
   logic                locked;

   typedef struct {
      logic [NCH-1:0] ce;
      logic [NCH-1:0] oc;
      logic           lk;
   } exp_t;

   exp_t exp_q[$];

   int total_cnt = 0;
   int bad_cnt   = 0;

   int             m_inc [NCH];
   int             m_acc [NCH];
   logic [NCH-1:0] m_ce;
   logic [NCH-1:0] m_out;
   int             m_quiet;

   clken_gen #(
      .NUM_CH   (NCH),
      .ACC_W    (AW),
      .LOCK_CYC (LCYC)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .inc    (inc),
      .inc_wr (inc_wr),
      .sync   (sync),
      .ce     (ce),
      .outclk (outclk),
      .locked (locked)
   );

   // Free-running reference clock, 10 time units per period.
   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   // Compare one observed value against the bench's prediction.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_cnt++;
      if (observed !== expected) begin
         bad_cnt++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Model state after reset.
   task automatic modelReset();
      for (int i = 0; i < NCH; i++) begin
         m_inc[i] = 0;
         m_acc[i] = 0;
      end
      m_ce    = '0;
      m_out   = '0;
      m_quiet = 0;
   endtask

   // Advance the model by one edge using the inputs currently driven.
   task automatic modelEdge();
      int s;
      for (int i = 0; i < NCH; i++) begin
         s = m_acc[i] + m_inc[i];
         if (sync) begin
            m_acc[i] = 0;
            m_ce[i]  = 1'b0;
            m_out[i] = 1'b0;
         end else if (s >= MODV) begin
            m_acc[i] = s - MODV;
            m_ce[i]  = 1'b1;
            m_out[i] = ~m_out[i];
         end else begin
            m_acc[i] = s;
            m_ce[i]  = 1'b0;
         end
         if (inc_wr) begin
            m_inc[i] = int'(inc[i*AW +: AW]);
         end
      end
      if (inc_wr || sync) begin
         m_quiet = 0;
      end else if (m_quiet < 1000) begin
         m_quiet++;
      end
   endtask

   // Run one clock: predict, queue, then sample just after the edge and compare.
   task automatic runCycle();
      exp_t e;
      modelEdge();
      e.ce = m_ce;
      e.oc = m_out;
      e.lk = (m_quiet >= LCYC);
      exp_q.push_back(e);
      @(posedge refclk);
      #1;
      if (exp_q.size() == 0) begin
         checkOutput("queue_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         checkOutput("ce", 32'(ce), 32'(e.ce));
         checkOutput("outclk", 32'(outclk), 32'(e.oc));
         checkOutput("locked", 32'(locked), 32'(e.lk));
      end
   endtask

   // Drive one cycle of strobes/increments, then return them to idle.
   task automatic applyStimulus(input logic wr, input logic [NCH*AW-1:0] val, input logic sy);
      inc    = val;
      inc_wr = wr;
      sync   = sy;
      runCycle();
      inc_wr = 1'b0;
      sync   = 1'b0;
   endtask

   initial begin
      int  win_cnt;
      bit  found;

      inc    = '0;
      inc_wr = 1'b0;
      sync   = 1'b0;
      rst    = 1'b0;
      modelReset();
      #1;
      checkOutput("reset_ce", 32'(ce), 32'd0);
      checkOutput("reset_outclk", 32'(outclk), 32'd0);
      checkOutput("reset_locked", 32'(locked), 32'd0);

      @(negedge refclk);
      rst = 1'b1;

      $display("[TB] idle after reset: no pulses, lock at edge %0d", LCYC);
      for (int c = 0; c < 20; c++) runCycle();

      $display("[TB] ch0=4 ch1=3 ch2=0 for 160 cycles");
      applyStimulus(1'b1, {4'd0, 4'd3, 4'd4}, 1'b0);
      win_cnt = 0;
      for (int c = 1; c <= 160; c++) begin
         runCycle();
         if (ce[1]) win_cnt++;
         if ((c % 16) == 0) begin
            checkOutput("ce1_window", 32'(win_cnt), 32'd3);
            win_cnt = 0;
         end
      end

      $display("[TB] sync mid-run");
      for (int c = 0; c < 5; c++) runCycle();
      applyStimulus(1'b0, {4'd0, 4'd3, 4'd4}, 1'b1);
      checkOutput("sync_outclk_zero", 32'(outclk), 32'd0);
      checkOutput("sync_ce_zero", 32'(ce), 32'd0);
      for (int c = 0; c < 24; c++) runCycle();

      $display("[TB] sync with inc_wr: ch0=8 ch1=15 ch2=0");
      applyStimulus(1'b1, {4'd0, 4'd15, 4'd8}, 1'b1);
      runCycle();
      checkOutput("sync_wr_first_edge_ce0", 32'(ce[0]), 32'd0);
      runCycle();
      checkOutput("sync_wr_second_edge_ce0", 32'(ce[0]), 32'd1);
      for (int c = 0; c < 20; c++) runCycle();

      $display("[TB] async reset while ce and locked are high");
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         runCycle();
         if (m_ce[1] && (m_quiet >= LCYC)) found = 1'b1;
      end
      if (!found) begin
         checkOutput("wait_ce_locked", 32'd0, 32'd1);
      end
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_rst_ce", 32'(ce), 32'd0);
      checkOutput("async_rst_outclk", 32'(outclk), 32'd0);
      checkOutput("async_rst_locked", 32'(locked), 32'd0);
      modelReset();
      @(negedge refclk);
      rst = 1'b1;

      $display("[TB] after reset release: no pulses until a nonzero increment");
      for (int c = 0; c < 20; c++) runCycle();
      applyStimulus(1'b1, {4'd1, 4'd0, 4'd15}, 1'b0);
      for (int c = 0; c < 40; c++) runCycle();

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
